// File: rtl/hack_cpu_pkg.sv
// -----------------------------------------------------------------------------
// hack_cpu_pkg
// Shared definitions for the Hack CPU control path.
//   DEF_ADDR_W / DEF_DATA_W : default instruction-address and datapath widths
//   jump_e                  : C-instruction jump field encodings (j1 j2 j3)
//   state_e                 : program-counter sequencing state
// -----------------------------------------------------------------------------
package hack_cpu_pkg;

    localparam int DEF_ADDR_W = 15;  // 32K-word instruction ROM
    localparam int DEF_DATA_W = 16;  // A-register / datapath width

    // j1 = lt (MSB), j2 = eq, j3 = gt (LSB)
    typedef enum logic [2:0] {
        JNULL = 3'b000,
        JGT   = 3'b001,
        JEQ   = 3'b010,
        JGE   = 3'b011,
        JLT   = 3'b100,
        JNE   = 3'b101,
        JLE   = 3'b110,
        JMP   = 3'b111
    } jump_e;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/jump_cond.sv
// -----------------------------------------------------------------------------
// jump_cond
// Purely combinational evaluation of the Hack jump field against ALU flags.
// Ports:
//   jump [2:0] in  : j1 j2 j3 (lt, eq, gt)
//   zr         in  : ALU result is zero
//   ng         in  : ALU result is negative
//   cond       out : jump condition satisfied
// The illegal flag pair zr=ng=1 is evaluated literally: the lt and eq terms
// may fire, the gt term never does.
// -----------------------------------------------------------------------------
module jump_cond (
    input  logic [2:0] jump,
    input  logic       zr,
    input  logic       ng,
    output logic       cond
);

    logic lt_hit;
    logic eq_hit;
    logic gt_hit;

    assign lt_hit = jump[2] & ng;
    assign eq_hit = jump[1] & zr;
    assign gt_hit = jump[0] & ~ng & ~zr;
    assign cond   = lt_hit | eq_hit | gt_hit;

endmodule

// File: rtl/pc_jump_unit.sv
// -----------------------------------------------------------------------------
// pc_jump_unit
// Program counter and jump resolution for the Hack CPU. Each cycle the PC
// either holds (stall), loads the A-register target (taken jump) or
// increments. An unconditional jump to the current PC is the Hack
// end-of-program idiom and parks the unit in HALTED until reset.
//
// Parameters:
//   ADDR_W    : instruction address width
//   DATA_W    : A-register width (bits above ADDR_W are ignored)
//   RESET_VEC : PC value after reset
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   stall      in  : hold PC and state this cycle
//   c_instr    in  : current instruction is a C-instruction
//   jump       in  : j1 j2 j3 jump field
//   zr, ng     in  : ALU zero / negative flags
//   a_reg      in  : jump target
//   pc         out : current instruction address (registered)
//   jump_taken out : registered pulse, previous update was a jump
//   halted     out : registered, self-jump idiom detected
//   jump_count out : taken-jump counter, saturating (only with
//                    PC_JUMP_COUNT_EN defined)
// Build option: define PC_JUMP_COUNT_EN to add the jump_count port.
// -----------------------------------------------------------------------------
module pc_jump_unit
    import hack_cpu_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              c_instr,
    input  logic [2:0]        jump,
    input  logic              zr,
    input  logic              ng,
    input  logic [DATA_W-1:0] a_reg,
    output logic [ADDR_W-1:0] pc,
    output logic              jump_taken,
    output logic              halted
`ifdef PC_JUMP_COUNT_EN
   ,output logic [15:0]       jump_count
`endif
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              jump_taken_q;
    logic              jump_taken_d;
    state_e            state_q;
    state_e            state_d;

    logic              cond;
    logic              take;
    logic              halt_hit;
    logic [ADDR_W-1:0] target;

    jump_cond u_jump_cond (
        .jump (jump),
        .zr   (zr),
        .ng   (ng),
        .cond (cond)
    );

    assign target = a_reg[ADDR_W-1:0];

    // Upper A-register bits never address the ROM.
    generate
        if (DATA_W > ADDR_W) begin : g_a_hi
            logic unused_a_hi;
            assign unused_a_hi = ^a_reg[DATA_W-1:ADDR_W];
        end
    endgenerate

    assign take     = c_instr & cond & ~stall & (state_q == RUN);
    // Only the unconditional form halts; a conditional self-jump is an
    // ordinary taken jump (it may be a spin-wait on a flag).
    assign halt_hit = take & (jump == JMP) & (target == pc_q);

    always_comb begin
        pc_d         = pc_q;
        jump_taken_d = 1'b0;
        state_d      = state_q;
        if ((state_q == RUN) && !stall) begin
            if (halt_hit) begin
                state_d      = HALTED;
                jump_taken_d = 1'b1;
            end else if (take) begin
                pc_d         = target;
                jump_taken_d = 1'b1;
            end else begin
                pc_d = pc_q + 1'b1;  // wraps naturally at 2^ADDR_W
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VEC;
            jump_taken_q <= 1'b0;
            state_q      <= RUN;
        end else begin
            pc_q         <= pc_d;
            jump_taken_q <= jump_taken_d;
            state_q      <= state_d;
        end
    end

    assign pc         = pc_q;
    assign jump_taken = jump_taken_q;
    assign halted     = (state_q == HALTED);

`ifdef PC_JUMP_COUNT_EN
    logic [15:0] jump_count_q;
    logic [15:0] jump_count_d;

    always_comb begin
        jump_count_d = jump_count_q;
        if (jump_taken_d && (jump_count_q != 16'hFFFF)) begin
            jump_count_d = jump_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_count_q <= '0;
        end else begin
            jump_count_q <= jump_count_d;
        end
    end

    assign jump_count = jump_count_q;
`endif

endmodule

// File: tb/tb_pc_jump_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_jump_unit
// Directed bench for pc_jump_unit with a scoreboard of expected outputs.
// Build option: define PC_JUMP_COUNT_EN to also check jump_count.
// -----------------------------------------------------------------------------
module tb_pc_jump_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        c_instr = 1'b0;
    logic [2:0]  jump = 3'b000;
    logic        zr = 1'b0;
    logic        ng = 1'b0;
    logic [15:0] a_reg = 16'h0000;
    logic [14:0] pc;
    logic        jump_taken;
    logic        halted;
`ifdef PC_JUMP_COUNT_EN
    logic [15:0] jump_count;
`endif

    pc_jump_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .c_instr    (c_instr),
        .jump       (jump),
        .zr         (zr),
        .ng         (ng),
        .a_reg      (a_reg),
        .pc         (pc),
        .jump_taken (jump_taken),
        .halted     (halted)
`ifdef PC_JUMP_COUNT_EN
       ,.jump_count (jump_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] pc;
        logic        jt;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;

    // Reference state
    logic [14:0] m_pc = 15'h0000;
    logic        m_halted = 1'b0;
    logic [15:0] m_cnt = 16'h0000;

    // Taken table per flag pair, bit index = jump code.
    function automatic logic [7:0] taken_mask(input logic z, input logic n);
        case ({z, n})
            2'b10:   taken_mask = 8'hCC;  // JEQ JGE JLE JMP
            2'b01:   taken_mask = 8'hF0;  // JLT JNE JLE JMP
            2'b00:   taken_mask = 8'hAA;  // JGT JGE JNE JMP
            default: taken_mask = 8'hFC;  // illegal zr=ng=1: lt/eq terms only
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        chk({tag, ".pc"}, {17'd0, pc}, {17'd0, e.pc});
        chk({tag, ".jump_taken"}, {31'd0, jump_taken}, {31'd0, e.jt});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e.halted});
`ifdef PC_JUMP_COUNT_EN
        chk({tag, ".jump_count"}, {16'd0, jump_count}, {16'd0, e.cnt});
`endif
        $display("[TB] %-10s pc=%04h jt=%0b halted=%0b", tag, pc, jump_taken, halted);
    endtask

    // Drive one cycle of inputs (called at posedge+1), predict, then check.
    task automatic step(input logic s, input logic c, input logic [2:0] j,
                        input logic z, input logic n, input logic [15:0] a,
                        input string tag);
        exp_t       e;
        logic [7:0] mask;
        logic       tk;
        stall = s; c_instr = c; jump = j; zr = z; ng = n; a_reg = a;
        mask = taken_mask(z, n);
        tk   = !m_halted && !s && c && mask[j];
        e.jt = 1'b0;
        if (!m_halted && !s) begin
            if (tk && (j == 3'b111) && (a[14:0] == m_pc)) begin
                m_halted = 1'b1;
                e.jt     = 1'b1;
            end else if (tk) begin
                m_pc = a[14:0];
                e.jt = 1'b1;
            end else begin
                m_pc = m_pc + 15'd1;
            end
        end
        if (e.jt && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
        e.pc     = m_pc;
        e.halted = m_halted;
        e.cnt    = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        // ---- reset state ----
        #2;
        chk("reset.pc", {17'd0, pc}, 32'd0);
        chk("reset.jump_taken", {31'd0, jump_taken}, 32'd0);
        chk("reset.halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Released at negedge, so the first posedge already advanced pc to 1.
        m_pc = 15'd1;
        chk("reset.first_inc", {17'd0, pc}, 32'd1);

        // ---- sequential fetch ----
        for (int i = 0; i < 4; i++) step(0, 0, 3'b111, 0, 0, 16'h0003, "seq");
        chk("seq.pc5", {17'd0, pc}, 32'd5);

        // ---- JEQ taken / not taken from pc=0x0010 ----
        step(0, 1, 3'b111, 0, 0, 16'h0010, "go10");
        step(0, 1, 3'b010, 1, 0, 16'h0100, "jeq_tk");
        chk("jeq_tk.pc", {17'd0, pc}, 32'h0100);
        step(0, 0, 3'b000, 0, 0, 16'h0000, "jeq_pulse");
        chk("jeq_pulse.jt", {31'd0, jump_taken}, 32'd0);
        step(0, 1, 3'b111, 0, 0, 16'h0010, "go10b");
        step(0, 1, 3'b010, 0, 0, 16'h0100, "jeq_nt");
        chk("jeq_nt.pc", {17'd0, pc}, 32'h0011);

        // ---- all jump codes x flag combos (incl. illegal zr=ng=1) ----
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 8; j++) begin
                logic [15:0] tgt;
                logic        zf;
                logic        nf;
                tgt = 16'h5000 + 16'((f * 8 + j) * 4);
                if (j[0]) tgt = tgt | 16'h8000;  // upper bit must be ignored
                zf = (f == 0) || (f == 3);
                nf = (f == 1) || (f == 3);
                step(0, 1, 3'(j), zf, nf, tgt, "cond");
            end
        end
        // A-instruction never jumps
        step(0, 0, 3'b111, 1, 0, 16'h0123, "a_instr");

        // ---- wrap and upper-bit masking ----
        step(0, 1, 3'b111, 0, 0, 16'h7FFF, "go7fff");
        step(0, 0, 3'b000, 0, 0, 16'h0000, "wrap");
        chk("wrap.pc", {17'd0, pc}, 32'd0);
        step(0, 1, 3'b111, 0, 0, 16'hFFFF, "tgt_ffff");
        chk("tgt_ffff.pc", {17'd0, pc}, 32'h7FFF);
        step(0, 1, 3'b111, 0, 0, 16'h8005, "tgt_8005");
        chk("tgt_8005.pc", {17'd0, pc}, 32'h0005);

        // ---- stall ----
        step(0, 1, 3'b111, 0, 0, 16'h0020, "go20");
        step(1, 1, 3'b111, 0, 0, 16'h0040, "stall");
        chk("stall.pc", {17'd0, pc}, 32'h0020);
        step(0, 1, 3'b111, 0, 0, 16'h0040, "unstall");
        chk("unstall.pc", {17'd0, pc}, 32'h0040);
        step(1, 1, 3'b111, 0, 0, 16'h0040, "stall_halt");
        chk("stall_halt.halted", {31'd0, halted}, 32'd0);
        // conditional self-jump is not a halt
        step(0, 1, 3'b010, 1, 0, 16'h0041, "go41");
        step(0, 1, 3'b010, 1, 0, 16'h0041, "cond_self");
        chk("cond_self.halted", {31'd0, halted}, 32'd0);

        // ---- halt ----
        step(0, 1, 3'b111, 0, 0, 16'h0030, "go30");
        step(0, 1, 3'b111, 0, 0, 16'h0030, "halt");
        chk("halt.halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom), 16'($urandom), "halted_rnd");
        end
        chk("halted_rnd.pc", {17'd0, pc}, 32'h0030);

        // ---- asynchronous reset mid-cycle ----
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.pc", {17'd0, pc}, 32'd0);
        chk("async_rst.halted", {31'd0, halted}, 32'd0);
        chk("async_rst.jt", {31'd0, jump_taken}, 32'd0);
`ifdef PC_JUMP_COUNT_EN
        chk("async_rst.cnt", {16'd0, jump_count}, 32'd0);
`endif
        @(negedge clk);
        stall = 1'b0; c_instr = 1'b0;
        rst_n = 1'b1;
        m_pc = 15'd0; m_halted = 1'b0; m_cnt = 16'd0;
        @(posedge clk);
        #1;
        m_pc = 15'd1;
        chk("post_rst.pc", {17'd0, pc}, 32'd1);
        step(0, 0, 3'b000, 0, 0, 16'h0000, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
